// File: rtl/sat_addsub_seq.sv
// rtl/sat_addsub_seq.sv - multi-cycle saturating signed add/subtract over one reused CLA slice
// Walks the operands SLICE bits per cycle, then saturates and publishes result/flags with done.
module sat_addsub_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             N,
  output logic             Z,
  output logic             V
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int MSB    = WIDTH - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bop_r;
  logic [WIDTH-1:0] partial;
  logic             carry;
  logic             c_msb_in;
  logic [IW-1:0]    idx;

  logic [SLICE-1:0] sa, sb, sg, sp, ss;
  logic [SLICE:0]   c_all;
  logic             cc;
  logic             ovf;
  logic [WIDTH-1:0] sat_res;

  // Carry-lookahead slice: every carry is formed from generate/propagate terms and the slice carry-in.
  always_comb begin
    sa    = a_r[idx*SLICE +: SLICE];
    sb    = bop_r[idx*SLICE +: SLICE];
    sg    = sa & sb;
    sp    = sa ^ sb;
    c_all = '0;
    cc    = 1'b0;
    for (int i = 0; i <= SLICE; i++) begin
      cc = carry;
      for (int j = 0; j < i; j++) cc = sg[j] | (sp[j] & cc);
      c_all[i] = cc;
    end
    ss = sp ^ c_all[SLICE-1:0];
  end

  // After the last slice, carry holds the carry out of bit MSB.
  always_comb begin
    ovf     = c_msb_in ^ carry;
    sat_res = ovf ? {a_r[MSB], {(WIDTH-1){~a_r[MSB]}}} : partial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_r      <= '0;
      bop_r    <= '0;
      partial  <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      N        <= 1'b0;
      Z        <= 1'b0;
      V        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= A;
            bop_r <= op_sub ? ~B : B;
            carry <= op_sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          partial[idx*SLICE +: SLICE] <= ss;
          carry <= c_all[SLICE];
          if (idx == IW'(NSLICE - 1)) begin
            c_msb_in <= c_all[SLICE-1];
            state    <= ST_DONE;
          end
          idx <= idx + 1'b1;
        end
        ST_DONE: begin
          result <= sat_res;
          N      <= sat_res[MSB];
          Z      <= (sat_res == '0);
          V      <= ovf;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sat_addsub_seq.sv
// tb/tb_sat_addsub_seq.sv - randomized self-checking bench for sat_addsub_seq
module tb_sat_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic [15:0] A, B;
  logic        busy, done;
  logic [15:0] result;
  logic        N, Z, V;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sat_addsub_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .A(A), .B(B), .busy(busy), .done(done), .result(result),
    .N(N), .Z(Z), .V(V)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed arithmetic, then clamp to the 16-bit range.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       output logic [15:0] res, output logic ovf);
    int r;
    r   = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    ovf = (r > 32767) || (r < -32768);
    if (r > 32767)       res = 16'h7FFF;
    else if (r < -32768) res = 16'h8000;
    else                 res = 16'(r);
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [15:0] er;
    logic        ev;
    int          n;
    model(a, b, sub, er, ev);
    @(negedge clk);
    A = a; B = b; op_sub = sub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, 5);
    check({tag, "_res"}, result, er);
    check({tag, "_flags"}, {N, Z, V}, {er[15], er == 16'h0, ev});
    @(posedge clk); #1;
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int          e;
    int          pulses;
    int          q[$];
    logic [15:0] held;

    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, N, Z, V, result}, 0);
    rst_n = 1'b1;

    do_op("add_1_1",      16'h0001, 16'h0001, 1'b0);
    do_op("pos_ovf",      16'h7FFF, 16'h0001, 1'b0);
    do_op("neg_ovf_sub",  16'h8000, 16'h0001, 1'b1);
    do_op("neg_ovf_add",  16'h8000, 16'h8000, 1'b0);
    do_op("sub_zero",     16'h1234, 16'h1234, 1'b1);
    do_op("carry_chain",  16'h000F, 16'h0001, 1'b0);
    do_op("min_min_sub",  16'h8000, 16'h8000, 1'b1);
    do_op("zero_min_sub", 16'h0000, 16'h8000, 1'b1);
    do_op("m1_min_sub",   16'hFFFF, 16'h8000, 1'b1);

    for (int i = 0; i < 40; i++)
      do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom));

    // Second start while busy must be ignored.
    @(negedge clk);
    A = 16'h0005; B = 16'h0003; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    A = 16'h1111; B = 16'h1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; held = '0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) begin pulses++; held = result; end
    end
    check("busy_ignore_pulses", pulses, 1);
    check("busy_ignore_res", held, 16'h0008);

    // Reset in the middle of an operation.
    @(negedge clk);
    A = 16'h4000; B = 16'h4000; op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset", {busy, done, N, Z, V, result}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_reset", 16'hFFFF, 16'h0001, 1'b0);

    // Start held high: back-to-back operations every NSLICE+2 cycles.
    @(negedge clk);
    A = 16'h0003; B = 16'h0004; op_sub = 1'b0; start = 1'b1;
    for (e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (done) q.push_back(e);
      if (done) check("held_res", result, 16'h0007);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    check("held_count", q.size(), 5);
    if (q.size() >= 3) begin
      check("held_first", q[0], 5);
      check("held_gap1", q[1] - q[0], 6);
      check("held_gap2", q[2] - q[1], 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
